pifo_sched: RTL

PIFO_SCHED -- requirements
Module: pifo_sched

---
 rtl/pifo_sched.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pifo_sched.sv
// Front-end scheduler for a root PIFO: round-robin arbitration of push/pop requesters,
// registered tree commands, pop response capture and an occupancy counter.
module pifo_sched #(
  parameter int unsigned PTW  = 16,
  parameter int unsigned MTW  = 32,
  parameter int unsigned NREQ = 4,
  parameter int unsigned CAP  = 1023,
  parameter int unsigned CTW  = 10,
  parameter int unsigned GAP  = 1,
  localparam int unsigned EW  = MTW + PTW,
  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             i_clk,
  input  logic             i_arst_n,
  input  logic [NREQ-1:0]  i_req_vld,
  input  logic [NREQ-1:0]  i_req_op,
  input  logic [NREQ*EW-1:0] i_req_data,
  output logic [NREQ-1:0]  o_req_gnt,
  output logic             o_push,
  output logic [EW-1:0]    o_push_data,
  output logic             o_pop,
  input  logic [EW-1:0]    i_pop_data,
  output logic             o_rsp_vld,
  output logic [EW-1:0]    o_rsp_data,
  output logic [IDW-1:0]   o_rsp_id,
  output logic [CTW-1:0]   o_count,
  output logic             o_full,
  output logic             o_empty
);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e          state_q;
  logic [31:0]     gap_q;
  logic [IDW-1:0]  rr_q;
  logic [IDW-1:0]  pop_id_q;
  logic [CTW-1:0]  count_q;
  logic            push_q;
  logic            pop_q;
  logic [EW-1:0]   push_data_q;
  logic            rsp_vld_q;
  logic [EW-1:0]   rsp_data_q;
  logic [IDW-1:0]  rsp_id_q;

  logic [NREQ-1:0] elig;
  logic [IDW-1:0]  scan_idx;
  logic [IDW-1:0]  gnt_idx;
  logic            found;
  logic            grant;
  logic            grant_pop;

  assign o_full      = (count_q == CTW'(CAP));
  assign o_empty     = (count_q == '0);
  assign o_count     = count_q;
  assign o_push      = push_q;
  assign o_pop       = pop_q;
  assign o_push_data = push_data_q;
  assign o_rsp_vld   = rsp_vld_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_id    = rsp_id_q;

  always_comb begin
    elig = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      // vld gates the op bit so an undriven op on an idle requester cannot leak through
      elig[k] = i_req_vld[k] & (i_req_op[k] ? ~o_empty : ~o_full);
    end
    found    = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      scan_idx = IDW'((32'(rr_q) + i) % NREQ);
      if (!found && elig[scan_idx]) begin
        found   = 1'b1;
        gnt_idx = scan_idx;
      end
    end
    grant     = (state_q == StIdle) && found;
    grant_pop = i_req_op[gnt_idx];
    o_req_gnt = grant ? (NREQ'(1) << gnt_idx) : '0;
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q     <= StIdle;
      gap_q       <= '0;
      rr_q        <= '0;
      pop_id_q    <= '0;
      count_q     <= '0;
      push_q      <= 1'b0;
      pop_q       <= 1'b0;
      push_data_q <= '0;
      rsp_vld_q   <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
    end else begin
      push_q      <= grant && !grant_pop;
      pop_q       <= grant && grant_pop;
      push_data_q <= (grant && !grant_pop) ? i_req_data[32'(gnt_idx)*EW +: EW] : '0;
      rsp_vld_q   <= pop_q;
      if (pop_q) begin
        rsp_data_q <= i_pop_data;
        rsp_id_q   <= pop_id_q;
      end
      if (grant) begin
        pop_id_q <= gnt_idx;
        rr_q     <= IDW'((32'(gnt_idx) + 1) % NREQ);
        count_q  <= grant_pop ? (count_q - CTW'(1)) : (count_q + CTW'(1));
      end
      unique case (state_q)
        StIdle: begin
          if (grant && (GAP > 0)) begin
            state_q <= StWait;
            gap_q   <= GAP - 1;
          end
        end
        StWait: begin
          if (gap_q == '0) state_q <= StIdle;
          else             gap_q   <= gap_q - 1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
